// File: rtl/led_dec_pkg.sv
// Shared types and helpers for the LED channel decoder/scanner.
// Mode encoding matches the 2-bit mode pins directly.
package led_dec_pkg;

  localparam int MAX_LED_N = 32;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_PING_PONG = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_e;

  // Active-high one-hot of idx; indices at or beyond led_n give all zeros.
  function automatic logic [MAX_LED_N-1:0] onehot(input logic [4:0] idx, input int led_n);
    logic [MAX_LED_N-1:0] v;
    v = '0;
    if (int'(idx) < led_n) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_dec_prescaler.sv
// Scan-step prescaler: counts 0..TICK_DIV-1 while run is high, wrap pulses on the last count.
// Latency: wrap is combinational from the count; clear or !run forces the count to 0.
// Backpressure: none; clear overrides a coincident wrap.
module led_dec_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic run,
  output logic wrap
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign wrap = run && !clear && (cnt_q == CNT_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (clear || !run || wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_decode_scan.sv
// One-hot LED bank driver: direct load of sel, or autonomous up/down/ping-pong scan.
// Latency: sel load and scan steps land on led/idx one edge later; sel_ready depends on state only.
// Backpressure: sel_ready low outside DIRECT, sel_valid is then dropped. LED_DEC_ACT_LOW_EN inverts led.
module led_decode_scan
  import led_dec_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  output logic [(1<<SEL_W)-1:0]   led,
  output logic [SEL_W-1:0]        idx,
  output logic                    tick
);

  localparam int LED_N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(LED_N - 1);
`ifdef LED_DEC_ACT_LOW_EN
  localparam logic [LED_N-1:0] LED_INV = '1;
`else
  localparam logic [LED_N-1:0] LED_INV = '0;
`endif

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic             en_q;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             tick_q, step;
  logic [LED_N-1:0] led_q, led_d;
  logic             chg;
  logic             wrap;

  assign chg       = (en != en_q) || (mode != mode_q);
  assign sel_ready = (state_q == ST_DIRECT);
  assign led       = led_q;
  assign idx       = idx_q;
  assign tick      = tick_q;

  led_dec_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (chg),
    .run       (state_q == ST_SCAN),
    .wrap      (wrap)
  );

  // state_d is captured on the same edge as en_q/mode_q, so state_q always decodes them.
  always_comb begin
    state_d = ST_IDLE;
    idx_d   = idx_q;
    dir_d   = chg ? 1'b1 : dir_q;
    step    = 1'b0;
    if (en) state_d = (mode == MODE_DIRECT) ? ST_DIRECT : ST_SCAN;

    if (state_q == ST_DIRECT && sel_valid) begin
      idx_d = sel;
    end else if (state_q == ST_SCAN && wrap) begin
      step = 1'b1;
      unique case (mode_q)
        MODE_SCAN_UP:   idx_d = idx_q + SEL_W'(1);
        MODE_SCAN_DOWN: idx_d = idx_q - SEL_W'(1);
        MODE_PING_PONG: begin
          // Ends are shown once: turn around by stepping away from the end immediately.
          if (dir_q) begin
            if (idx_q == IDX_MAX) begin
              idx_d = idx_q - SEL_W'(1);
              dir_d = 1'b0;
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end else begin
            if (idx_q == '0) begin
              idx_d = idx_q + SEL_W'(1);
              dir_d = 1'b1;
            end else begin
              idx_d = idx_q - SEL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    led_d = '0;
    if (state_d != ST_IDLE) led_d = LED_N'(onehot(5'(idx_d), LED_N));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_DIRECT;
      en_q    <= 1'b0;
      idx_q   <= '0;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      led_q   <= LED_INV;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_e'(mode);
      en_q    <= en;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      tick_q  <= step;
      led_q   <= led_d ^ LED_INV;
    end
  end

endmodule

// File: tb/tb_led_decode_scan.sv
// Directed bench for led_decode_scan: one instance at TICK_DIV=4, one at TICK_DIV=1, shared inputs.
module tb_led_decode_scan;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] sel = 2'b00;
  logic       sel_valid = 1'b0;

  logic       rdy4, tick4, rdy1, tick1;
  logic [3:0] led4, led1;
  logic [1:0] idx4, idx1;

  int n_checks = 0;
  int n_fail = 0;
  int pp_seq[9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};

  always #5 sys_clk = ~sys_clk;

  led_decode_scan #(.SEL_W(2), .TICK_DIV(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode), .sel(sel),
    .sel_valid(sel_valid), .sel_ready(rdy4), .led(led4), .idx(idx4), .tick(tick4)
  );

  led_decode_scan #(.SEL_W(2), .TICK_DIV(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode), .sel(sel),
    .sel_valid(sel_valid), .sel_ready(rdy1), .led(led1), .idx(idx1), .tick(tick1)
  );

  function automatic logic [3:0] exp_led(input int i, input bit on);
    logic [3:0] v;
    v = on ? (4'b0001 << i) : 4'b0000;
`ifdef LED_DEC_ACT_LOW_EN
    v = ~v;
`endif
    return v;
  endfunction

  task automatic clk_step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; en = 1'b0; mode = 2'b00; sel = 2'b00; sel_valid = 1'b0;
    clk_step(2);
    sys_rst_n = 1'b1;
    clk_step(1);
  endtask

  task automatic test_reset();
    clk_step(2);
    n_checks++; if (led4 !== exp_led(0, 0)) begin n_fail++; $display("FAIL reset_led got %b exp %b", led4, exp_led(0, 0)); end
    n_checks++; if (idx4 !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", idx4); end
    n_checks++; if (tick4 !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick4); end
    n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", rdy4); end
    sys_rst_n = 1'b1;
    clk_step(3);
    n_checks++; if (rdy1 !== 1'b0 || led1 !== exp_led(0, 0)) begin n_fail++; $display("FAIL idle_after_reset rdy %b led %b exp 0 %b", rdy1, led1, exp_led(0, 0)); end
  endtask

  task automatic test_direct();
    do_reset();
    en = 1'b1; mode = 2'b00; sel = 2'b10;
    clk_step(1);
    n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL direct_ready got %b exp 1", rdy4); end
    n_checks++; if (led4 !== exp_led(0, 1)) begin n_fail++; $display("FAIL direct_led_pre got %b exp %b", led4, exp_led(0, 1)); end
    sel_valid = 1'b1;
    clk_step(1);
    sel_valid = 1'b0;
    n_checks++; if (idx4 !== 2'd2) begin n_fail++; $display("FAIL direct_idx2 got %0d exp 2", idx4); end
    n_checks++; if (led4 !== exp_led(2, 1)) begin n_fail++; $display("FAIL direct_led2 got %b exp %b", led4, exp_led(2, 1)); end
    n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL direct_ready_hold got %b exp 1", rdy4); end
    sel = 2'b01; sel_valid = 1'b1;
    clk_step(1);
    sel_valid = 1'b0; sel = 2'b11;
    n_checks++; if (idx4 !== 2'd1 || led4 !== exp_led(1, 1)) begin n_fail++; $display("FAIL direct_load1 idx %0d led %b exp 1 %b", idx4, led4, exp_led(1, 1)); end
    clk_step(2);
    n_checks++; if (idx4 !== 2'd1) begin n_fail++; $display("FAIL direct_no_valid got %0d exp 1", idx4); end
    en = 1'b0;
    clk_step(1);
    sel_valid = 1'b1;
    clk_step(2);
    sel_valid = 1'b0;
    n_checks++; if (idx4 !== 2'd1 || rdy4 !== 1'b0 || led4 !== exp_led(0, 0)) begin n_fail++; $display("FAIL idle_ignore idx %0d rdy %b led %b exp 1 0 %b", idx4, rdy4, led4, exp_led(0, 0)); end
  endtask

  task automatic test_scan_up();
    do_reset();
    en = 1'b1; mode = 2'b00; sel = 2'b11;
    clk_step(1);
    sel_valid = 1'b1;
    clk_step(1);
    sel_valid = 1'b0;
    n_checks++; if (idx4 !== 2'd3) begin n_fail++; $display("FAIL up_preload got %0d exp 3", idx4); end
    mode = 2'b01;
    clk_step(1);
    for (int i = 0; i <= 12; i++) begin
      n_checks++; if (idx4 !== 2'((3 + i / 4) % 4)) begin n_fail++; $display("FAIL up_idx c%0d got %0d exp %0d", i, idx4, (3 + i / 4) % 4); end
      n_checks++; if (tick4 !== (i > 0 && i % 4 == 0)) begin n_fail++; $display("FAIL up_tick c%0d got %b", i, tick4); end
      n_checks++; if (led4 !== exp_led((3 + i / 4) % 4, 1)) begin n_fail++; $display("FAIL up_led c%0d got %b exp %b", i, led4, exp_led((3 + i / 4) % 4, 1)); end
      clk_step(1);
    end
  endtask

  task automatic test_ping_pong();
    do_reset();
    en = 1'b1; mode = 2'b11;
    clk_step(1);
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (idx1 !== 2'(pp_seq[i])) begin n_fail++; $display("FAIL pp_idx c%0d got %0d exp %0d", i, idx1, pp_seq[i]); end
      n_checks++; if (tick1 !== (i > 0)) begin n_fail++; $display("FAIL pp_tick c%0d got %b exp %b", i, tick1, i > 0); end
      n_checks++; if (led1 !== exp_led(pp_seq[i], 1)) begin n_fail++; $display("FAIL pp_led c%0d got %b exp %b", i, led1, exp_led(pp_seq[i], 1)); end
      clk_step(1);
    end
  endtask

  task automatic test_wrap_change();
    do_reset();
    en = 1'b1; mode = 2'b10;
    clk_step(1);
    n_checks++; if (idx4 !== 2'd0 || tick4 !== 1'b0) begin n_fail++; $display("FAIL down_start idx %0d tick %b exp 0 0", idx4, tick4); end
    clk_step(4);
    n_checks++; if (idx4 !== 2'd3 || tick4 !== 1'b1) begin n_fail++; $display("FAIL down_wrap idx %0d tick %b exp 3 1", idx4, tick4); end
    clk_step(3);
    mode = 2'b01;
    clk_step(1);
    n_checks++; if (idx4 !== 2'd3 || tick4 !== 1'b0) begin n_fail++; $display("FAIL change_wins idx %0d tick %b exp 3 0", idx4, tick4); end
    clk_step(3);
    n_checks++; if (idx4 !== 2'd3 || tick4 !== 1'b0) begin n_fail++; $display("FAIL change_wait idx %0d tick %b exp 3 0", idx4, tick4); end
    clk_step(1);
    n_checks++; if (idx4 !== 2'd0 || tick4 !== 1'b1) begin n_fail++; $display("FAIL change_up_step idx %0d tick %b exp 0 1", idx4, tick4); end
    clk_step(4);
    n_checks++; if (idx4 !== 2'd1 || tick4 !== 1'b1) begin n_fail++; $display("FAIL change_up_step2 idx %0d tick %b exp 1 1", idx4, tick4); end
  endtask

  task automatic test_en_drop();
    clk_step(1);
    en = 1'b0; sel = 2'b11; sel_valid = 1'b1;
    clk_step(1);
    n_checks++; if (led4 !== exp_led(0, 0)) begin n_fail++; $display("FAIL drop_led got %b exp %b", led4, exp_led(0, 0)); end
    n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL drop_ready got %b exp 0", rdy4); end
    n_checks++; if (idx4 !== 2'd1) begin n_fail++; $display("FAIL drop_idx got %0d exp 1", idx4); end
    clk_step(6);
    n_checks++; if (idx4 !== 2'd1 || tick4 !== 1'b0 || led4 !== exp_led(0, 0)) begin n_fail++; $display("FAIL drop_hold idx %0d tick %b led %b exp 1 0 %b", idx4, tick4, led4, exp_led(0, 0)); end
    en = 1'b1; mode = 2'b00; sel_valid = 1'b0;
    clk_step(1);
    n_checks++; if (led4 !== exp_led(1, 1) || idx4 !== 2'd1) begin n_fail++; $display("FAIL restore led %b idx %0d exp %b 1", led4, idx4, exp_led(1, 1)); end
    n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL restore_ready got %b exp 1", rdy4); end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; mode = 2'b01;
    clk_step(5);
    n_checks++; if (idx4 !== 2'd1 || led4 !== exp_led(1, 1)) begin n_fail++; $display("FAIL arst_pre idx %0d led %b exp 1 %b", idx4, led4, exp_led(1, 1)); end
    #3;
    sys_rst_n = 1'b0;
    #1;
    n_checks++; if (led4 !== exp_led(0, 0)) begin n_fail++; $display("FAIL arst_led got %b exp %b", led4, exp_led(0, 0)); end
    n_checks++; if (idx4 !== 2'd0 || idx1 !== 2'd0) begin n_fail++; $display("FAIL arst_idx got %0d %0d exp 0 0", idx4, idx1); end
    n_checks++; if (tick1 !== 1'b0 || tick4 !== 1'b0) begin n_fail++; $display("FAIL arst_tick got %b %b exp 0 0", tick1, tick4); end
    n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL arst_ready got %b exp 0", rdy4); end
    clk_step(2);
    sys_rst_n = 1'b1;
    en = 1'b0; mode = 2'b00;
    clk_step(2);
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_up();
    test_ping_pong();
    test_wrap_change();
    test_en_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
